battousai_store: RTL and testbench

- Store-side counterpart to the load extender in the multicycle RV64 datapath.
- Performs sb/sh/sw/sd as a read-modify-write on the 64-bit doubleword-addressed data memory.
- Reads the current doubleword, merges the low byte, half or word of rs2 into its low bits, and writes the result back.
- Lane placement matches the load path: the byte/half/word always occupies the low bits of Dataout/Datain.

---
 rtl/battousai_store_if.sv | 22 ++
 rtl/battousai_store.sv | 124 ++++++++++++
 tb/tb_battousai_store.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/battousai_store_if.sv
// Request/memory bundle between the datapath controller and the store read-modify-write unit.
interface battousai_store_if;
  logic        start;
  logic [31:0] Register_Intruction_Instr31_0;
  logic [63:0] Store_Data;
  logic [63:0] Dataout;
  logic [63:0] Datain;
  logic        Mem_Wr;
  logic        busy;
  logic        done;
  logic        store_err;

  modport master (
    output start, Register_Intruction_Instr31_0, Store_Data, Dataout,
    input  Datain, Mem_Wr, busy, done, store_err
  );

  modport slave (
    input  start, Register_Intruction_Instr31_0, Store_Data, Dataout,
    output Datain, Mem_Wr, busy, done, store_err
  );
endinterface

// File: rtl/battousai_store.sv
// RV64 store unit: sb/sh/sw merge into the low lanes of the read doubleword, sd overwrites directly.
module battousai_store #(
  parameter int unsigned MEM_READ_LAT = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  battousai_store_if.slave   bus
);

  localparam int unsigned CNT_W      = 4;
  localparam int unsigned DW         = 64;
  localparam logic [6:0]  OPC_STORE  = 7'd35;
  localparam logic [2:0]  F3_SD      = 3'd3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_READ_LAT - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       funct3_q, funct3_d;
  logic [DW-1:0]    sdata_q, sdata_d;
  logic             err_q, err_d;
  logic [DW-1:0]    datain_q, datain_d;
  logic             mem_wr_q, mem_wr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             store_err_q, store_err_d;

  logic [6:0]       opcode_c;
  logic [2:0]       funct3_in_c;
  logic             legal_c;
  logic [DW-1:0]    merged_c;

  assign opcode_c    = bus.Register_Intruction_Instr31_0[6:0];
  assign funct3_in_c = bus.Register_Intruction_Instr31_0[14:12];
  assign legal_c     = (opcode_c == OPC_STORE) && !funct3_in_c[2];

  // Low-lane merge; upper memory bits pass through untouched (no extension on stores).
  always_comb begin
    merged_c = bus.Dataout;
    case (funct3_q)
      3'd0:    merged_c = {bus.Dataout[63:8],  sdata_q[7:0]};
      3'd1:    merged_c = {bus.Dataout[63:16], sdata_q[15:0]};
      default: merged_c = {bus.Dataout[63:32], sdata_q[31:0]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    funct3_d = funct3_q;
    sdata_d  = sdata_q;
    err_d    = err_q;
    datain_d = datain_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          funct3_d = funct3_in_c;
          sdata_d  = bus.Store_Data;
          err_d    = !legal_c;
          cnt_d    = '0;
          if (!legal_c) begin
            state_d = DONE;
          end else if (funct3_in_c == F3_SD) begin
            state_d  = WRITE;
            datain_d = bus.Store_Data;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (cnt_q == CNT_LAST) begin
          datain_d = merged_c;
          state_d  = WRITE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs registered from the next state so they line up with the state they describe.
    mem_wr_d    = (state_d == WRITE);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    store_err_d = (state_d == DONE) && err_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      funct3_q    <= '0;
      sdata_q     <= '0;
      err_q       <= 1'b0;
      datain_q    <= '0;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      store_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      funct3_q    <= funct3_d;
      sdata_q     <= sdata_d;
      err_q       <= err_d;
      datain_q    <= datain_d;
      mem_wr_q    <= mem_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      store_err_q <= store_err_d;
    end
  end

  assign bus.Datain    = datain_q;
  assign bus.Mem_Wr    = mem_wr_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.store_err = store_err_q;

endmodule

// File: tb/tb_battousai_store.sv
// Directed bench for battousai_store: lane merges, sd bypass, illegal requests, latency, reset abort.
module tb_battousai_store;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  battousai_store_if b1 ();
  battousai_store_if b3 ();

  battousai_store #(.MEM_READ_LAT(1)) u_lat1 (.clk(clk), .reset_n(reset_n), .bus(b1.slave));
  battousai_store #(.MEM_READ_LAT(3)) u_lat3 (.clk(clk), .reset_n(reset_n), .bus(b3.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [2:0] f3, input logic [6:0] opc);
    return {17'h0, f3, 5'h0, opc};
  endfunction

  // One request on the LAT=1 unit; a second start is thrown at it one cycle later and
  // the operands are scrambled, so only the originally latched request may write.
  task automatic do_op1(input string tag, input logic [31:0] instr, input logic [63:0] sdata,
                        input logic [63:0] dout, input logic [63:0] exp_d, input int exp_lat,
                        input logic exp_err, input logic exp_wr);
    int done_cyc = -1;
    int n_done = 0;
    int n_wr = 0;
    logic err_at_done = 1'b0;
    logic [63:0] wr_data = '0;
    @(negedge clk);
    b1.start = 1'b1;
    b1.Register_Intruction_Instr31_0 = instr;
    b1.Store_Data = sdata;
    b1.Dataout = dout;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) check({tag, "_busy"}, 64'(b1.busy), 64'd1);
      if (b1.done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = i;
          err_at_done = b1.store_err;
        end
      end
      if (b1.Mem_Wr) begin
        if (n_wr == 0) wr_data = b1.Datain;
        n_wr++;
      end
      if (i == 1) begin
        b1.start = 1'b1;
        b1.Register_Intruction_Instr31_0 = mk_instr(3'd0, 7'd35);
        b1.Store_Data = 64'h0;
      end else begin
        b1.start = 1'b0;
      end
      if (exp_lat == 2) b1.Dataout = {$urandom, $urandom};
    end
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_lat));
    check({tag, "_done_count"}, 64'(n_done), 64'd1);
    check({tag, "_err"}, 64'(err_at_done), 64'(exp_err));
    check({tag, "_wr_count"}, 64'(n_wr), exp_wr ? 64'd1 : 64'd0);
    if (exp_wr) begin
      check({tag, "_datain"}, wr_data, exp_d);
      check({tag, "_datain_hold"}, b1.Datain, exp_d);
    end
    check({tag, "_idle"}, 64'(b1.busy), 64'd0);
  endtask

  initial begin
    int done_cyc;
    int n_wr;
    logic [63:0] wr_data;

    b1.start = 1'b0; b1.Register_Intruction_Instr31_0 = '0; b1.Store_Data = '0; b1.Dataout = '0;
    b3.start = 1'b0; b3.Register_Intruction_Instr31_0 = '0; b3.Store_Data = '0; b3.Dataout = '0;
    repeat (2) @(negedge clk);
    check("rst_datain", b1.Datain, 64'h0);
    check("rst_flags", {60'h0, b1.Mem_Wr, b1.busy, b1.done, b1.store_err}, 64'h0);
    reset_n = 1'b1;
    @(negedge clk);

    do_op1("sb", mk_instr(3'd0, 7'd35), 64'hFFFF_FFFF_FFFF_FFAB, 64'h1122334455667788,
           64'h11223344556677AB, 3, 1'b0, 1'b1);
    do_op1("sh", mk_instr(3'd1, 7'd35), 64'hFFFF_FFFF_FFFF_CDEF, 64'h1122334455667788,
           64'h112233445566CDEF, 3, 1'b0, 1'b1);
    do_op1("sw", mk_instr(3'd2, 7'd35), 64'hFFFF_FFFF_DEAD_BEEF, 64'h1122334455667788,
           64'h11223344DEADBEEF, 3, 1'b0, 1'b1);
    do_op1("sd", mk_instr(3'd3, 7'd35), 64'h0123456789ABCDEF, 64'h1122334455667788,
           64'h0123456789ABCDEF, 2, 1'b0, 1'b1);
    do_op1("ill_f3", mk_instr(3'd4, 7'd35), 64'h1, 64'h2, 64'h0, 1, 1'b1, 1'b0);
    do_op1("ill_opc", mk_instr(3'd0, 7'd3), 64'h1, 64'h2, 64'h0, 1, 1'b1, 1'b0);

    // LAT=3 sb: Dataout is only meaningful in the last READ cycle.
    done_cyc = -1; n_wr = 0; wr_data = '0;
    @(negedge clk);
    b3.start = 1'b1;
    b3.Register_Intruction_Instr31_0 = mk_instr(3'd0, 7'd35);
    b3.Store_Data = 64'h5555_5555_5555_5500;
    b3.Dataout = 64'hDEAD_0000_BEEF_1111;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (b3.done && done_cyc < 0) done_cyc = i;
      if (b3.Mem_Wr) begin
        if (n_wr == 0) wr_data = b3.Datain;
        n_wr++;
      end
      b3.start = 1'b0;
      b3.Store_Data = 64'h0;
      b3.Dataout = (i < 2) ? 64'h1357_9BDF_2468_ACE0 : 64'hAAAA_AAAA_AAAA_AAAA;
    end
    check("lat3_done_cycle", 64'(done_cyc), 64'd5);
    check("lat3_wr_count", 64'(n_wr), 64'd1);
    check("lat3_datain", wr_data, 64'hAAAAAAAAAAAAAA00);

    // Abort mid-READ on the LAT=3 unit.
    @(negedge clk);
    b3.start = 1'b1;
    b3.Register_Intruction_Instr31_0 = mk_instr(3'd1, 7'd35);
    b3.Store_Data = 64'h1234;
    @(negedge clk);
    b3.start = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 64'(b3.busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_datain", b3.Datain, 64'h0);
    check("mid_rst_flags", {60'h0, b3.Mem_Wr, b3.busy, b3.done, b3.store_err}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    n_wr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b3.Mem_Wr || b3.busy) n_wr++;
    end
    check("post_rst_no_activity", 64'(n_wr), 64'd0);

    do_op1("sb_after_rst", mk_instr(3'd0, 7'd35), 64'h0000_0000_0000_0042, 64'hFEDC_BA98_7654_3210,
           64'hFEDC_BA98_7654_3242, 3, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
